// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer types and geometry constants
package fb_pkg;

  // Framebuffer geometry, shared with the VGA readout and paint blocks
  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 12;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } fsm_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// rtl/fb_port_arbiter_if.sv - display/paint/clear/RAM bus bundle for the framebuffer arbiter
interface fb_port_arbiter_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
);

  // Display read port
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  // Paint write port
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_ovf;

  // Clear sequencer control
  logic              clr_req;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
  logic              clr_done;

  // Framebuffer RAM command/response
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, clr_req, clr_color, mem_rdata,
    output rd_valid, rd_data, wr_ready, wr_ovf, clr_busy, clr_done,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Surrounding design side (paint, VGA readout, RAM)
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, clr_req, clr_color, mem_rdata,
    input  rd_valid, rd_data, wr_ready, wr_ovf, clr_busy, clr_done,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/fb_port_arbiter_wr_fifo.sv
// rtl/fb_port_arbiter_wr_fifo.sv - small synchronous FIFO buffering paint writes
module wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Overflowing pushes and underflowing pops are ignored rather than corrupting state
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - single-port framebuffer arbiter: display reads, buffered paint writes, clear fill
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int DATA_W   = FB_DATA_W,
  parameter int WF_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  fb_port_arbiter_if.slave   io_bus
);

  localparam int                ENT_W     = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  // Sequencer state
  fsm_t              r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [DATA_W-1:0] r_clr_color;
  logic              r_clr_done;
  logic              r_wr_ovf;

  // Read return pipeline
  logic              r_rd_pend;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  // Write FIFO view
  logic                      w_full;
  logic                      w_empty;
  logic [$clog2(WF_DEPTH):0] w_count;
  logic [ENT_W-1:0]          w_head;
  logic                      w_push;
  logic                      w_pop;

  // RAM command for the current cycle
  logic              w_wr_ready;
  logic              w_clr_issue;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  // Paint writes are only accepted while idle so a clear never races fresh pixels
  assign w_wr_ready = !w_full && (r_state == IDLE);
  assign w_push     = io_bus.wr_req && w_wr_ready;

  wr_fifo #(
    .DEPTH (WF_DEPTH),
    .WIDTH (ENT_W)
  ) u_wr_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  ({io_bus.wr_addr, io_bus.wr_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // One RAM command per cycle: display read, then clear fill, then buffered paint
  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_pop       = 1'b0;
    w_clr_issue = 1'b0;
    if (i_rst) begin
      if (io_bus.rd_req) begin
        w_mem_en   = 1'b1;
        w_mem_addr = io_bus.rd_addr;
      end else if (r_state == CLEAR) begin
        w_mem_en    = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_addr;
        w_mem_wdata = r_clr_color;
        w_clr_issue = 1'b1;
      end else if (!w_empty) begin
        w_mem_en    = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = w_head[ENT_W-1:DATA_W];
        w_mem_wdata = w_head[DATA_W-1:0];
        w_pop       = 1'b1;
      end
    end
  end

  // Clear sequencing: flush pending paint, then sweep every address once
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= IDLE;
      r_clr_addr  <= '0;
      r_clr_color <= '0;
      r_clr_done  <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_bus.clr_req) begin
            r_state     <= DRAIN;
            r_clr_color <= io_bus.clr_color;
          end
        end
        DRAIN: begin
          if (w_count == '0) r_state <= CLEAR;
        end
        CLEAR: begin
          // The sweep only advances on cycles the display left free; the wrap returns it to 0
          if (w_clr_issue) begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (r_clr_addr == LAST_ADDR) begin
              r_state    <= IDLE;
              r_clr_done <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky record that a paint write was lost
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ovf <= 1'b0;
    end else if (io_bus.wr_req && !w_wr_ready) begin
      r_wr_ovf <= 1'b1;
    end
  end

  // Two-cycle read return: RAM answers next cycle, then the pixel is registered
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_pend  <= w_mem_en && !w_mem_we;
      r_rd_valid <= r_rd_pend;
      if (r_rd_pend) r_rd_data <= io_bus.mem_rdata;
    end
  end

  assign io_bus.rd_valid  = r_rd_valid;
  assign io_bus.rd_data   = r_rd_data;
  assign io_bus.wr_ready  = w_wr_ready;
  assign io_bus.wr_ovf    = r_wr_ovf;
  assign io_bus.clr_busy  = (r_state != IDLE);
  assign io_bus.clr_done  = r_clr_done;
  assign io_bus.mem_en    = w_mem_en;
  assign io_bus.mem_we    = w_mem_we;
  assign io_bus.mem_addr  = w_mem_addr;
  assign io_bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - directed self-checking bench for fb_port_arbiter
module tb_fb_port_arbiter;

  localparam int AW    = 11;
  localparam int DW    = 12;
  localparam int DEPTH = 4;
  localparam int NPIX  = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_port_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .WF_DEPTH (DEPTH)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  function automatic logic [DW-1:0] init_pix(input int a);
    return DW'(a * 37 + 5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Framebuffer RAM: one-cycle read latency, contents seeded on the first edge
  logic [DW-1:0] ram [NPIX];
  bit            ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < NPIX; i++) ram[i] <= init_pix(i);
      ram_init <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // Reference model: queue-based FIFO, mode number, shadow pixel array
  int            m_mode = 0;
  int            qa[$];
  logic [DW-1:0] qd[$];
  int            m_caddr = 0;
  logic [DW-1:0] m_color = '0;
  bit            m_ovf = 0, m_done = 0;
  bit            m_p1v = 0, m_p2v = 0;
  logic [DW-1:0] m_p1d = '0, m_p2d = '0;
  logic [DW-1:0] shadow [NPIX];
  bit            sh_init = 0;

  // Compare every cycle against the model, then advance the model with this cycle's inputs
  always @(negedge clk) begin : model
    bit            e_en, e_we, e_rdy, fifo_wr, clr_wr;
    int            e_addr;
    logic [DW-1:0] e_wd;
    if (!sh_init) begin
      for (int i = 0; i < NPIX; i++) shadow[i] = init_pix(i);
      sh_init = 1;
    end
    if (!rst) begin
      m_mode = 0; qa.delete(); qd.delete(); m_caddr = 0;
      m_ovf = 0; m_done = 0; m_p1v = 0; m_p2v = 0;
    end else begin
      e_rdy = (qa.size() < DEPTH) && (m_mode == 0);
      e_en = 0; e_we = 0; e_addr = 0; e_wd = '0; fifo_wr = 0; clr_wr = 0;
      if (bus.rd_req) begin
        e_en = 1; e_addr = int'(bus.rd_addr);
      end else if (m_mode == 2) begin
        e_en = 1; e_we = 1; e_addr = m_caddr; e_wd = m_color; clr_wr = 1;
      end else if (qa.size() > 0) begin
        e_en = 1; e_we = 1; e_addr = qa[0]; e_wd = qd[0]; fifo_wr = 1;
      end
      chk("mem_en", bus.mem_en, e_en);
      chk("mem_we", bus.mem_we, e_we);
      if (e_en) chk("mem_addr", bus.mem_addr, e_addr);
      if (e_we) chk("mem_wdata", bus.mem_wdata, e_wd);
      chk("rd_valid", bus.rd_valid, m_p2v);
      if (m_p2v) chk("rd_data", bus.rd_data, m_p2d);
      chk("wr_ready", bus.wr_ready, e_rdy);
      chk("wr_ovf", bus.wr_ovf, m_ovf);
      chk("clr_busy", bus.clr_busy, m_mode != 0);
      chk("clr_done", bus.clr_done, m_done);

      m_done = 0;
      if (bus.wr_req && !e_rdy) m_ovf = 1;
      m_p2v = m_p1v; m_p2d = m_p1d;
      m_p1v = bus.rd_req;
      if (bus.rd_req) m_p1d = shadow[bus.rd_addr];
      case (m_mode)
        0: if (bus.clr_req) begin m_mode = 1; m_color = bus.clr_color; end
        1: if (qa.size() == 0) m_mode = 2;
        2: if (clr_wr) begin
             if (m_caddr == NPIX - 1) begin m_mode = 0; m_caddr = 0; m_done = 1; end
             else m_caddr++;
           end
        default: m_mode = 0;
      endcase
      if (e_we) shadow[e_addr] = e_wd;
      if (fifo_wr) begin void'(qa.pop_front()); void'(qd.pop_front()); end
      if (bus.wr_req && e_rdy) begin qa.push_back(int'(bus.wr_addr)); qd.push_back(bus.wr_data); end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  // Run a clear already requested by the caller, checking the sweep and its side effects
  task automatic do_clear(input bit alt, input logic [DW-1:0] col, input int exp_wr, input string tag);
    int nwr = 0, ndone = 0, nbad = 0, nrdy = 0, nclash = 0, next_a = 0, cyc = 0, nram = 0;
    bit fin = 0;
    while (!fin && cyc < 4 * NPIX) begin
      look();
      if (bus.mem_we) begin
        nwr++;
        if (bus.clr_busy && bus.mem_wdata == col) begin
          if (int'(bus.mem_addr) != next_a) nbad++;
          next_a++;
        end
      end
      if (bus.rd_req && bus.mem_we) nclash++;
      if (bus.clr_busy && bus.wr_ready) nrdy++;
      if (bus.clr_done) begin ndone++; fin = 1; end
      tick();
      cyc++;
      bus.clr_req = 1'b0;
      if (alt) begin
        bus.rd_req  = ~bus.rd_req;
        bus.rd_addr = AW'(cyc * 3);
      end
    end
    bus.rd_req = 1'b0;
    chk({tag, " finished"}, fin, 1);
    chk({tag, " total writes"}, nwr, exp_wr);
    chk({tag, " clear addrs"}, next_a, NPIX);
    chk({tag, " addr order errs"}, nbad, 0);
    chk({tag, " write under read"}, nclash, 0);
    chk({tag, " wr_ready while busy"}, nrdy, 0);
    chk({tag, " done pulses"}, ndone, 1);
    look();
    chk({tag, " done one cycle"}, bus.clr_done, 0);
    for (int i = 0; i < NPIX; i++) if (ram[i] != col) nram++;
    chk({tag, " ram fill"}, nram, 0);
    tick();
  endtask

  initial begin
    int nw, nv, nv_early, cyc, nd;
    bit hit;
    bus.rd_req = 0; bus.rd_addr = '0; bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clr_req = 0; bus.clr_color = '0;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;

    // Reset state
    look();
    chk("reset rd_valid", bus.rd_valid, 0);
    chk("reset rd_data", bus.rd_data, 0);
    chk("reset wr_ovf", bus.wr_ovf, 0);
    chk("reset clr_busy", bus.clr_busy, 0);
    chk("reset clr_done", bus.clr_done, 0);
    chk("reset wr_ready", bus.wr_ready, 1);
    chk("reset mem_en", bus.mem_en, 0);
    tick();

    // Single paint write lands on the next cycle
    bus.wr_req = 1; bus.wr_addr = 11'h102; bus.wr_data = 12'h743;
    tick();
    bus.wr_req = 0;
    look();
    chk("t1 mem_we", bus.mem_we, 1);
    chk("t1 mem_addr", bus.mem_addr, 32'h102);
    chk("t1 mem_wdata", bus.mem_wdata, 32'h743);
    tick();

    // Reads starve writes; writes drain in order once reads stop
    nw = 0; nv = 0; nv_early = 0;
    for (int i = 0; i < 10; i++) begin
      bus.rd_req = 1; bus.rd_addr = AW'(i);
      bus.wr_req = (i < 3); bus.wr_addr = AW'(32'h200 + i); bus.wr_data = DW'(32'hA00 + i);
      look();
      if (bus.mem_we) nw++;
      if (bus.rd_valid) begin
        if (i >= 2) nv++;
        else nv_early++;
      end
      tick();
    end
    bus.rd_req = 0; bus.wr_req = 0;
    chk("t2 writes during reads", nw, 0);
    chk("t2 rd_valid run", nv, 8);
    chk("t2 rd_valid early", nv_early, 0);
    for (int i = 0; i < 3; i++) begin
      look();
      chk("t2 drain we", bus.mem_we, 1);
      chk("t2 drain addr", bus.mem_addr, 32'h200 + i);
      chk("t2 drain data", bus.mem_wdata, 32'hA00 + i);
      tick();
    end

    // FIFO overflow under continuous reads
    bus.rd_req = 1; bus.rd_addr = 11'h010;
    for (int i = 0; i < 5; i++) begin
      bus.wr_req = 1; bus.wr_addr = AW'(32'h300 + i); bus.wr_data = DW'(32'hB00 + i);
      look();
      chk("t3 wr_ready", bus.wr_ready, (i < 4) ? 1 : 0);
      tick();
    end
    bus.wr_req = 0;
    look();
    chk("t3 wr_ovf set", bus.wr_ovf, 1);
    tick();
    bus.rd_req = 0;
    for (int i = 0; i < 4; i++) begin
      look();
      chk("t3 drain addr", bus.mem_addr, 32'h300 + i);
      tick();
    end
    look();
    chk("t3 fifth dropped", bus.mem_en, 0);
    chk("t3 wr_ovf sticky", bus.wr_ovf, 1);
    tick();

    // Clear with two pending paint writes
    bus.rd_req = 1;
    bus.wr_req = 1; bus.wr_addr = 11'h055; bus.wr_data = 12'h0AB;
    tick();
    bus.wr_addr = 11'h056; bus.wr_data = 12'h0CD;
    tick();
    bus.wr_req = 0; bus.rd_req = 0;
    bus.clr_req = 1; bus.clr_color = 12'h111;
    do_clear(0, 12'h111, NPIX + 2, "t4");

    // Clear interleaved with reads every other cycle
    bus.clr_req = 1; bus.clr_color = 12'h3C5;
    do_clear(1, 12'h3C5, NPIX, "t5");

    // Reset in the middle of a clear
    bus.clr_req = 1; bus.clr_color = 12'h5E7;
    tick();
    bus.clr_req = 0;
    cyc = 0; hit = 0;
    while (!hit && cyc < 4 * NPIX) begin
      look();
      if (bus.mem_we && bus.clr_busy && bus.mem_addr == 11'h400) hit = 1;
      tick();
      cyc++;
    end
    chk("t6 reached 0x400", hit, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    look();
    chk("t6 clr_busy", bus.clr_busy, 0);
    chk("t6 wr_ready", bus.wr_ready, 1);
    chk("t6 clr_done", bus.clr_done, 0);
    chk("t6 ram 0x400", ram[11'h400], 32'h5E7);
    chk("t6 ram 0x401", ram[11'h401], 32'h3C5);
    nd = 0;
    repeat (5) begin
      tick();
      look();
      if (bus.clr_done) nd++;
    end
    chk("t6 no done", nd, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
